// File: rtl/pwm_capture.sv
// PWM capture: recovers on-time and period (in sample ticks) of a PWM input.
// Optional macro PWM_CAP_GLITCH_EN adds a two-tick agreement filter on the input level.
module pwm_capture #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         smp_clk,
  input  logic         pwm_in,
  output logic [N-1:0] t_on,
  output logic [N-1:0] period,
  output logic         valid,
  output logic         overflow
);

  localparam logic [N-1:0] CTR_ZERO = {N{1'b0}};
  localparam logic [N-1:0] CTR_ONE  = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0] CTR_MAX  = {N{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ARM  = 2'b01,
    HIGH = 2'b10,
    LOW  = 2'b11
  } state_t;

  state_t      state;
  logic        sync1;
  logic        sync2;
  logic        prev;
  logic        lvl;
  logic        rise;
  logic [N-1:0] hi_ctr;
  logic [N-1:0] per_ctr;

  // Two-flop synchronizer, free-running on clk regardless of ticks.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= pwm_in;
      sync2 <= sync1;
    end
  end

`ifdef PWM_CAP_GLITCH_EN
  logic raw_prev;

  // Raw synchronized sample from the previous tick, used to require two agreeing ticks.
  always_ff @(posedge clk) begin
    if (!reset) begin
      raw_prev <= 1'b1;
    end else if (smp_clk) begin
      raw_prev <= sync2;
    end else begin
      raw_prev <= raw_prev;
    end
  end

  // prev holds the last accepted level, so a disagreeing sample keeps it.
  always_comb begin
    if (sync2 == raw_prev) begin
      lvl = sync2;
    end else begin
      lvl = prev;
    end
  end
`else
  // Unfiltered level: the synchronized input as seen on this tick.
  always_comb begin
    lvl = sync2;
  end
`endif

  // Rising edge between the previous tick's level and this tick's level.
  always_comb begin
    rise = lvl & ~prev;
  end

  // Measurement FSM, counters and registered results; everything advances on ticks only.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      prev     <= 1'b1;
      hi_ctr   <= CTR_ZERO;
      per_ctr  <= CTR_ZERO;
      t_on     <= CTR_ZERO;
      period   <= CTR_ZERO;
      valid    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (smp_clk) begin
        prev <= lvl;
        case (state)
          IDLE: begin
            hi_ctr  <= CTR_ZERO;
            per_ctr <= CTR_ZERO;
            if (!lvl) begin
              state <= ARM;
            end
          end
          ARM: begin
            if (rise) begin
              state   <= HIGH;
              hi_ctr  <= CTR_ONE;
              per_ctr <= CTR_ONE;
            end
          end
          HIGH: begin
            if (per_ctr == CTR_MAX) begin
              overflow <= 1'b1;
              hi_ctr   <= CTR_ZERO;
              per_ctr  <= CTR_ZERO;
              state    <= IDLE;
            end else if (lvl) begin
              hi_ctr  <= hi_ctr + CTR_ONE;
              per_ctr <= per_ctr + CTR_ONE;
            end else begin
              per_ctr <= per_ctr + CTR_ONE;
              state   <= LOW;
            end
          end
          LOW: begin
            // Any high level here is a rise, since the previous tick was low.
            if (rise) begin
              t_on     <= hi_ctr;
              period   <= per_ctr;
              valid    <= 1'b1;
              overflow <= 1'b0;
              hi_ctr   <= CTR_ONE;
              per_ctr  <= CTR_ONE;
              state    <= HIGH;
            end else if (per_ctr == CTR_MAX) begin
              overflow <= 1'b1;
              hi_ctr   <= CTR_ZERO;
              per_ctr  <= CTR_ZERO;
              state    <= IDLE;
            end else begin
              per_ctr <= per_ctr + CTR_ONE;
            end
          end
          default: begin
            state   <= IDLE;
            hi_ctr  <= CTR_ZERO;
            per_ctr <= CTR_ZERO;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Randomized self-checking bench for pwm_capture, compared every clk against a
// timestamp-based reference model (honours PWM_CAP_GLITCH_EN when defined).
module tb_pwm_capture;

  localparam int N = 8;
  localparam int MAXC = (1 << N) - 1;

  logic         clk;
  logic         reset;
  logic         smp_clk;
  logic         pwm_in;
  logic [N-1:0] t_on;
  logic [N-1:0] period;
  logic         valid;
  logic         overflow;

  int errors;
  int checks;

  pwm_capture #(.N(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .smp_clk  (smp_clk),
    .pwm_in   (pwm_in),
    .t_on     (t_on),
    .period   (period),
    .valid    (valid),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: measurement expressed as tick timestamps of edges.
  logic         m_s1, m_s2, m_prev, m_raw_prev;
  bit           m_armed, m_meas, m_fall_seen;
  int           tk, m_rise_t, m_fall_t;
  logic [N-1:0] e_ton, e_per;
  logic         e_valid, e_ovf;

  always @(posedge clk) begin
    logic cur;
    logic l;
    logic r;
    if (!reset) begin
      m_s1 = 1'b1; m_s2 = 1'b1; m_prev = 1'b1; m_raw_prev = 1'b1;
      m_armed = 1'b0; m_meas = 1'b0; m_fall_seen = 1'b0;
      tk = 0; m_rise_t = 0; m_fall_t = 0;
      e_ton = '0; e_per = '0; e_valid = 1'b0; e_ovf = 1'b0;
    end else begin
      cur = m_s2;
      m_s2 = m_s1;
      m_s1 = pwm_in;
      e_valid = 1'b0;
      if (smp_clk) begin
`ifdef PWM_CAP_GLITCH_EN
        l = (cur == m_raw_prev) ? cur : m_prev;
        m_raw_prev = cur;
`else
        l = cur;
`endif
        r = l && !m_prev;
        m_prev = l;
        if (m_meas) begin
          if (r && m_fall_seen) begin
            e_ton = N'(m_fall_t - m_rise_t);
            e_per = N'(tk - m_rise_t);
            e_valid = 1'b1;
            e_ovf = 1'b0;
            m_rise_t = tk;
            m_fall_seen = 1'b0;
          end else if (tk - m_rise_t == MAXC) begin
            e_ovf = 1'b1;
            m_meas = 1'b0;
          end else if (!l && !m_fall_seen) begin
            m_fall_seen = 1'b1;
            m_fall_t = tk;
          end
        end else if (m_armed) begin
          if (r) begin
            m_meas = 1'b1;
            m_armed = 1'b0;
            m_rise_t = tk;
            m_fall_seen = 1'b0;
          end
        end else if (!l) begin
          m_armed = 1'b1;
        end
        tk++;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // One clk: check outputs of the last edge, then apply the next inputs.
  task automatic cyc(input logic rst, input logic s, input logic p);
    @(negedge clk);
    check("valid", {31'd0, valid}, {31'd0, e_valid});
    check("overflow", {31'd0, overflow}, {31'd0, e_ovf});
    check("t_on", {24'd0, t_on}, {24'd0, e_ton});
    check("period", {24'd0, period}, {24'd0, e_per});
    reset = rst;
    smp_clk = s;
    pwm_in = p;
  endtask

  // DAC-like source: each tick lasts div clks; optional single-tick low glitch mid-high.
  task automatic dac(input int ton, input int per, input int div, input int nper, input bit glitch);
    for (int n = 0; n < nper; n++) begin
      for (int ph = 0; ph < per; ph++) begin
        logic lv;
        lv = (ph < ton);
        if (glitch && ton >= 3 && ph == ton / 2) lv = 1'b0;
        for (int d = 0; d < div; d++) begin
          cyc(1'b1, (d == div - 1), lv);
        end
      end
    end
  endtask

  task automatic hold(input logic lv, input int nticks);
    for (int i = 0; i < nticks; i++) cyc(1'b1, 1'b1, lv);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b0;
    smp_clk = 1'b0;
    pwm_in = 1'b0;
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);

    dac(3, 10, 1, 6, 1'b0);
    dac(128, 255, 4, 3, 1'b0);

    dac(3, 10, 1, 4, 1'b0);
    hold(1'b1, 300);
    dac(3, 10, 1, 5, 1'b0);
    hold(1'b0, 300);
    dac(3, 10, 1, 5, 1'b0);

    dac(3, 10, 1, 3, 1'b0);
    hold(1'b1, 3);
    hold(1'b0, 2);
    cyc(1'b0, 1'b1, 1'b0);
    dac(3, 10, 1, 5, 1'b0);

    dac(1, 2, 1, 10, 1'b0);
    dac(5, 10, 1, 6, 1'b1);
    dac(5, 10, 2, 4, 1'b0);

    for (int it = 0; it < 16; it++) begin
      int per;
      int ton;
      int div;
      per = int'($urandom_range(2, 40));
      ton = int'($urandom_range(1, per - 1));
      div = int'($urandom_range(1, 4));
      dac(ton, per, div, int'($urandom_range(3, 6)), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 4) == 0) begin
        cyc(1'b0, 1'b1, 1'b0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
